// File: rtl/wlm_sched.sv
// Round-robin scheduler sharing one fixed-latency Montgomery reduction pipeline among N_REQ
// requesters. Define WLM_SCHED_STATS_EN to add per-requester grant counters (stat_sel/stat_cnt).
module wlm_sched #(
    parameter int unsigned LOGQ  = 32,
    parameter int unsigned LOGQH = 15,
    parameter int unsigned LOGT  = 32,
    parameter int unsigned LAT   = 6,
    parameter int unsigned N_REQ = 4,
    localparam int unsigned LOGC = 2 * LOGQ,
    localparam int unsigned IDW  = $clog2(N_REQ)
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    cfg_valid,
    input  logic [LOGQH-1:0]        cfg_qh,
    output logic                    cfg_ready,
    input  logic [N_REQ-1:0]        req_valid,
    input  logic [N_REQ*LOGC-1:0]   req_c,
    output logic [N_REQ-1:0]        req_ready,
    output logic [LOGC-1:0]         pipe_c,
    output logic [LOGQH-1:0]        pipe_qh,
    input  logic [LOGT-1:0]         pipe_t,
    output logic                    out_valid,
    output logic [IDW-1:0]          out_id,
    output logic [LOGT-1:0]         out_t,
`ifdef WLM_SCHED_STATS_EN
    output logic                    busy,
    input  logic [IDW-1:0]          stat_sel,
    output logic [31:0]             stat_cnt
`else
    output logic                    busy
`endif
);

    localparam int unsigned CW = $clog2(LAT + 2);

    typedef enum logic [1:0] {StUncfg, StRun, StDrain, StLoad} state_e;

    state_e         state_q, state_d;
    logic [IDW-1:0] rr_q, rr_next;
    logic [IDW-1:0] gnt_id, scan_idx;
    logic           grant_en, xfer, retire;
    logic [CW-1:0]  inflight_q;
    logic [LAT:0]   tag_vld_q;
    logic [IDW-1:0] tag_id_q [LAT+1];

    always_ff @(posedge clk) begin
        if (rst) state_q <= StUncfg;
        else     state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            StUncfg: if (cfg_valid) state_d = StLoad;
            StRun:   if (cfg_valid) state_d = StDrain;
            StDrain: if (inflight_q == '0) state_d = StLoad;
            StLoad:  state_d = StRun;
            default: state_d = StUncfg;
        endcase
    end

    // A pending reconfiguration takes priority over any grant in the same cycle.
    always_comb begin
        cfg_ready = (state_q == StLoad);
        grant_en  = (state_q == StRun) && !cfg_valid;
    end

    always_comb begin
        xfer     = 1'b0;
        gnt_id   = '0;
        scan_idx = '0;
        for (int unsigned k = 0; k < N_REQ; k++) begin
            scan_idx = IDW'((32'(rr_q) + k) % N_REQ);
            if (grant_en && !xfer && req_valid[scan_idx]) begin
                xfer   = 1'b1;
                gnt_id = scan_idx;
            end
        end
        req_ready = xfer ? (N_REQ'(1) << gnt_id) : '0;
        rr_next   = (gnt_id == IDW'(N_REQ - 1)) ? '0 : gnt_id + 1'b1;
    end

    assign retire = tag_vld_q[LAT];
    assign busy   = (inflight_q != '0);

    // Tag stage LAT lines up with pipe_t for the op that entered LAT+1 edges earlier.
    always_ff @(posedge clk) begin
        if (rst) begin
            rr_q       <= '0;
            inflight_q <= '0;
            tag_vld_q  <= '0;
            for (int unsigned i = 0; i <= LAT; i++) tag_id_q[i] <= '0;
            pipe_c     <= '0;
            pipe_qh    <= '0;
            out_valid  <= 1'b0;
            out_id     <= '0;
            out_t      <= '0;
        end else begin
            if (xfer) begin
                pipe_c <= req_c[gnt_id*LOGC +: LOGC];
                rr_q   <= rr_next;
            end
            if (state_q == StLoad) pipe_qh <= cfg_qh;
            inflight_q  <= inflight_q + CW'(xfer) - CW'(retire);
            tag_vld_q   <= {tag_vld_q[LAT-1:0], xfer};
            tag_id_q[0] <= gnt_id;
            for (int unsigned i = 1; i <= LAT; i++) tag_id_q[i] <= tag_id_q[i-1];
            out_valid <= retire;
            if (retire) begin
                out_id <= tag_id_q[LAT];
                out_t  <= pipe_t;
            end
        end
    end

`ifdef WLM_SCHED_STATS_EN
    logic [31:0] cnt_q [N_REQ];

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int unsigned k = 0; k < N_REQ; k++) cnt_q[k] <= '0;
            stat_cnt <= '0;
        end else begin
            if (xfer && (cnt_q[gnt_id] != '1)) cnt_q[gnt_id] <= cnt_q[gnt_id] + 32'd1;
            stat_cnt <= (32'(stat_sel) < N_REQ) ? cnt_q[stat_sel] : '0;
        end
    end
`endif

endmodule

// File: tb/tb_wlm_sched.sv
// Self-checking bench for wlm_sched: queue-based reference model plus a stand-in
// reduction pipeline that delays {C, qH} by LAT clocks and folds them into T.
module tb_wlm_sched;
    localparam int LAT = 6;
    localparam int N   = 4;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          cfg_valid = 1'b0;
    logic [14:0]   cfg_qh = '0;
    logic          cfg_ready;
    logic [3:0]    req_valid = '0;
    logic [255:0]  req_c = '0;
    logic [3:0]    req_ready;
    logic [63:0]   pipe_c;
    logic [14:0]   pipe_qh;
    logic [31:0]   pipe_t;
    logic          out_valid;
    logic [1:0]    out_id;
    logic [31:0]   out_t;
    logic          busy;

    always #5 clk = ~clk;

    wlm_sched #(.LOGQ(32), .LOGQH(15), .LOGT(32), .LAT(LAT), .N_REQ(N)) dut (
        .clk(clk), .rst(rst), .cfg_valid(cfg_valid), .cfg_qh(cfg_qh), .cfg_ready(cfg_ready),
        .req_valid(req_valid), .req_c(req_c), .req_ready(req_ready), .pipe_c(pipe_c),
        .pipe_qh(pipe_qh), .pipe_t(pipe_t), .out_valid(out_valid), .out_id(out_id),
        .out_t(out_t), .busy(busy)
    );

    function automatic logic [31:0] hash(input logic [63:0] c, input logic [14:0] q);
        return c[31:0] ^ c[63:32] ^ {17'b0, q};
    endfunction

    // Stand-in reduction unit: fixed latency LAT from registered C to T.
    logic [63:0] hist_c  [LAT];
    logic [14:0] hist_qh [LAT];
    always @(posedge clk) begin
        hist_c[0]  <= pipe_c;
        hist_qh[0] <= pipe_qh;
        for (int i = 1; i < LAT; i++) begin
            hist_c[i]  <= hist_c[i-1];
            hist_qh[i] <= hist_qh[i-1];
        end
    end
    assign pipe_t = hash(hist_c[LAT-1], hist_qh[LAT-1]);

    typedef struct {int id; logic [31:0] t; int due;} exp_t;
    exp_t        exp_q[$];
    int          cyc = 0, m_mode = 0, m_rr = 0, m_ld = 0;
    logic [14:0] m_qh = '0;
    int          n_chk = 0, n_fail = 0;

    logic [3:0]  e_gnt;
    int          e_id, e_out_id;
    logic        e_out_valid, e_busy, e_cfg_ready;
    logic [31:0] e_out_t;

    // m_mode: 0 unconfigured, 1 running, 2 reload pending (qH loads in cycle m_ld).
    task automatic predict();
        int i;
        #1;
        e_gnt = '0;
        e_id  = 0;
        if (m_mode == 1 && !cfg_valid)
            for (int k = 0; k < N; k++) begin
                i = (m_rr + k) % N;
                if (e_gnt == 4'b0 && req_valid[i]) begin
                    e_gnt[i] = 1'b1;
                    e_id     = i;
                end
            end
        e_out_valid = (exp_q.size() > 0) && (exp_q[0].due == cyc);
        e_out_id    = e_out_valid ? exp_q[0].id : 0;
        e_out_t     = e_out_valid ? exp_q[0].t : '0;
        e_busy      = 1'b0;
        foreach (exp_q[j]) if (exp_q[j].due > cyc) e_busy = 1'b1;
        e_cfg_ready = (m_mode == 2) && (cyc == m_ld);
    endtask

    task automatic advance();
        int last;
        @(posedge clk);
        if (rst) begin
            exp_q.delete();
            m_mode = 0;
            m_rr   = 0;
            m_qh   = '0;
        end else begin
            if (e_out_valid) void'(exp_q.pop_front());
            if (e_gnt != 4'b0) begin
                exp_q.push_back('{id: e_id, t: hash(req_c[e_id*64 +: 64], m_qh), due: cyc + LAT + 2});
                m_rr = (e_id + 1) % N;
            end
            if (m_mode == 2) begin
                if (cyc == m_ld) begin
                    m_qh   = cfg_qh;
                    m_mode = 1;
                end
            end else if (cfg_valid) begin
                if (m_mode == 0) m_ld = cyc + 1;
                else begin
                    last = cyc + 1;
                    foreach (exp_q[j]) if (exp_q[j].due > last) last = exp_q[j].due;
                    m_ld = last + 1;
                end
                m_mode = 2;
            end
        end
        cyc++;
        @(negedge clk);
    endtask

    task automatic rand_c();
        for (int s = 0; s < N; s++) req_c[s*64 +: 64] = {$urandom(), $urandom()};
    endtask

    task automatic test_reset();
        rst = 1'b1; req_valid = 4'hF;
        predict(); advance(); predict(); advance();
        rst = 1'b0;
        predict();
        n_chk += 8;
        if (out_valid !== 1'b0) begin n_fail++; $display("FAIL reset out_valid got=%b want=0", out_valid); end
        if (out_id !== 2'd0) begin n_fail++; $display("FAIL reset out_id got=%0d want=0", out_id); end
        if (out_t !== 32'd0) begin n_fail++; $display("FAIL reset out_t got=%h want=0", out_t); end
        if (pipe_c !== 64'd0) begin n_fail++; $display("FAIL reset pipe_c got=%h want=0", pipe_c); end
        if (pipe_qh !== 15'd0) begin n_fail++; $display("FAIL reset pipe_qh got=%h want=0", pipe_qh); end
        if (cfg_ready !== 1'b0) begin n_fail++; $display("FAIL reset cfg_ready got=%b want=0", cfg_ready); end
        if (busy !== 1'b0) begin n_fail++; $display("FAIL reset busy got=%b want=0", busy); end
        if (req_ready !== 4'b0) begin n_fail++; $display("FAIL reset req_ready got=%b want=0", req_ready); end
        advance();
        req_valid = '0;
    endtask

    task automatic test_config(input logic [14:0] qh);
        logic seen = 1'b0;
        int   k0 = cyc;
        cfg_qh = qh; cfg_valid = 1'b1; req_valid = 4'hF;
        for (int i = 0; i < 8 && !seen; i++) begin
            predict();
            n_chk += 2;
            if (req_ready !== 4'b0) begin n_fail++; $display("FAIL cfg no_grant cyc=%0d got=%b want=0000", cyc, req_ready); end
            if (cfg_ready !== e_cfg_ready) begin n_fail++; $display("FAIL cfg ready cyc=%0d got=%b want=%b", cyc, cfg_ready, e_cfg_ready); end
            seen = cfg_ready;
            advance();
        end
        cfg_valid = 1'b0; req_valid = '0;
        n_chk++;
        if (!seen) begin n_fail++; $display("FAIL cfg timeout got=no cfg_ready want=pulse"); end
        else if (cyc - k0 !== 2) begin n_fail++; $display("FAIL cfg latency got=%0d want=2", cyc - k0); end
        predict();
        n_chk++;
        if (pipe_qh !== qh) begin n_fail++; $display("FAIL cfg pipe_qh got=%h want=%h", pipe_qh, qh); end
        advance();
    endtask

    task automatic test_single();
        logic [63:0] c = 64'h0123_4567_89AB_CDEF;
        int due, n_out = 0;
        req_c = '0; req_c[63:0] = c; req_valid = 4'b0001;
        predict();
        n_chk++;
        if (req_ready !== 4'b0001) begin n_fail++; $display("FAIL single grant got=%b want=0001", req_ready); end
        due = cyc + LAT + 2;
        advance();
        req_valid = '0;
        for (int i = 0; i < LAT + 4; i++) begin
            predict();
            n_chk += 3;
            if (i == 0 && pipe_c !== c) begin n_fail++; $display("FAIL single pipe_c got=%h want=%h", pipe_c, c); end
            if (out_valid !== (cyc == due)) begin n_fail++; $display("FAIL single out_valid cyc=%0d got=%b want=%b", cyc, out_valid, cyc == due); end
            if (busy !== (cyc < due)) begin n_fail++; $display("FAIL single busy cyc=%0d got=%b want=%b", cyc, busy, cyc < due); end
            if (cyc == due) begin
                n_out++;
                n_chk += 2;
                if (out_id !== 2'd0) begin n_fail++; $display("FAIL single out_id got=%0d want=0", out_id); end
                if (out_t !== hash(c, 15'h1A2B)) begin n_fail++; $display("FAIL single out_t got=%h want=%h", out_t, hash(c, 15'h1A2B)); end
            end
            advance();
        end
        n_chk++;
        if (n_out !== 1) begin n_fail++; $display("FAIL single count got=%0d want=1", n_out); end
    endtask

    task automatic test_round_robin();
        logic [3:0] want;
        int n_out = 0;
        req_valid = 4'b1000; rand_c();
        predict(); advance();
        req_valid = 4'hF;
        for (int i = 0; i < 8 + LAT + 4; i++) begin
            if (i == 8) req_valid = '0;
            rand_c();
            predict();
            want = 4'b0001 << (i % 4);
            n_chk += 2;
            if (req_ready !== e_gnt) begin n_fail++; $display("FAIL rr model_grant cyc=%0d got=%b want=%b", cyc, req_ready, e_gnt); end
            if (out_valid !== e_out_valid) begin n_fail++; $display("FAIL rr out_valid cyc=%0d got=%b want=%b", cyc, out_valid, e_out_valid); end
            if (i < 8) begin
                n_chk += 2;
                if (req_ready !== want) begin n_fail++; $display("FAIL rr order cyc=%0d got=%b want=%b", cyc, req_ready, want); end
                if (busy !== 1'b1) begin n_fail++; $display("FAIL rr busy cyc=%0d got=%b want=1", cyc, busy); end
            end
            if (e_out_valid) begin
                n_chk += 2;
                if (out_id !== 2'((n_out + 3) % 4)) begin n_fail++; $display("FAIL rr out_id got=%0d want=%0d", out_id, (n_out + 3) % 4); end
                if (out_t !== e_out_t) begin n_fail++; $display("FAIL rr out_t got=%h want=%h", out_t, e_out_t); end
                n_out++;
            end
            advance();
        end
        n_chk++;
        if (n_out !== 9) begin n_fail++; $display("FAIL rr count got=%0d want=9", n_out); end
    endtask

    task automatic test_wrap_skip();
        logic [3:0] want [4];
        logic [3:0] pat  [4];
        pat  = '{4'b0100, 4'b0101, 4'b0101, 4'b1111};
        want = '{4'b0100, 4'b0001, 4'b0100, 4'b1000};
        for (int i = 0; i < 4 + LAT + 3; i++) begin
            req_valid = (i < 4) ? pat[i] : 4'b0;
            rand_c();
            predict();
            n_chk += 2;
            if (i < 4 && req_ready !== want[i]) begin n_fail++; $display("FAIL wrap grant step=%0d got=%b want=%b", i, req_ready, want[i]); end
            if (out_valid !== e_out_valid || (e_out_valid && out_id !== 2'(e_out_id))) begin
                n_fail++; $display("FAIL wrap out cyc=%0d got=%b/%0d want=%b/%0d", cyc, out_valid, out_id, e_out_valid, e_out_id);
            end
            advance();
        end
    endtask

    task automatic test_reconfig();
        int retired = 0;
        logic seen = 1'b0;
        req_valid = 4'hF;
        for (int i = 0; i < LAT + 3; i++) begin
            rand_c(); predict();
            n_chk++;
            if (req_ready !== e_gnt) begin n_fail++; $display("FAIL recfg stream cyc=%0d got=%b want=%b", cyc, req_ready, e_gnt); end
            advance();
        end
        cfg_qh = 15'h0555; cfg_valid = 1'b1;
        for (int i = 0; i < 20 && !seen; i++) begin
            rand_c(); predict();
            n_chk += 3;
            if (req_ready !== 4'b0) begin n_fail++; $display("FAIL recfg grant cyc=%0d got=%b want=0000", cyc, req_ready); end
            if (cfg_ready !== e_cfg_ready) begin n_fail++; $display("FAIL recfg ready cyc=%0d got=%b want=%b", cyc, cfg_ready, e_cfg_ready); end
            if (out_valid !== e_out_valid || (e_out_valid && out_t !== e_out_t)) begin
                n_fail++; $display("FAIL recfg out cyc=%0d got=%b/%h want=%b/%h", cyc, out_valid, out_t, e_out_valid, e_out_t);
            end
            if (i > 0 && out_valid) retired++;
            seen = cfg_ready;
            advance();
        end
        cfg_valid = 1'b0;
        n_chk += 2;
        if (!seen) begin n_fail++; $display("FAIL recfg timeout got=no cfg_ready want=pulse"); end
        if (retired !== LAT + 1) begin n_fail++; $display("FAIL recfg drained got=%0d want=%0d", retired, LAT + 1); end
        for (int i = 0; i < LAT + 5; i++) begin
            req_valid = (i < 2) ? 4'hF : 4'b0;
            rand_c(); predict();
            n_chk += 3;
            if (pipe_qh !== 15'h0555) begin n_fail++; $display("FAIL recfg pipe_qh got=%h want=0555", pipe_qh); end
            if (i == 0 && req_ready === 4'b0) begin n_fail++; $display("FAIL recfg resume got=%b want=one-hot", req_ready); end
            if (out_valid !== e_out_valid || (e_out_valid && out_t !== e_out_t)) begin
                n_fail++; $display("FAIL recfg newqh cyc=%0d got=%b/%h want=%b/%h", cyc, out_valid, out_t, e_out_valid, e_out_t);
            end
            advance();
        end
    endtask

    task automatic test_reset_midflight();
        req_valid = 4'hF;
        for (int i = 0; i < 3; i++) begin rand_c(); predict(); advance(); end
        rst = 1'b1; predict(); advance(); rst = 1'b0;
        for (int i = 0; i < LAT + 2; i++) begin
            predict();
            n_chk += 3;
            if (out_valid !== 1'b0) begin n_fail++; $display("FAIL midrst out_valid cyc=%0d got=%b want=0", cyc, out_valid); end
            if (req_ready !== 4'b0) begin n_fail++; $display("FAIL midrst grant cyc=%0d got=%b want=0000", cyc, req_ready); end
            if (busy !== 1'b0) begin n_fail++; $display("FAIL midrst busy cyc=%0d got=%b want=0", cyc, busy); end
            advance();
        end
        req_valid = '0;
    endtask

    task automatic test_random();
        logic ld = 1'b0;
        for (int i = 0; i < 400 + LAT + 4; i++) begin
            req_valid = (i < 400) ? 4'($urandom()) : 4'b0;
            rand_c();
            if (i < 400 && !cfg_valid && $urandom_range(0, 49) == 0) begin
                cfg_valid = 1'b1; cfg_qh = 15'($urandom());
            end
            predict();
            n_chk += 5;
            if (req_ready !== e_gnt) begin n_fail++; $display("FAIL rand grant cyc=%0d got=%b want=%b", cyc, req_ready, e_gnt); end
            if (out_valid !== e_out_valid) begin n_fail++; $display("FAIL rand out_valid cyc=%0d got=%b want=%b", cyc, out_valid, e_out_valid); end
            if (busy !== e_busy) begin n_fail++; $display("FAIL rand busy cyc=%0d got=%b want=%b", cyc, busy, e_busy); end
            if (cfg_ready !== e_cfg_ready) begin n_fail++; $display("FAIL rand cfg_ready cyc=%0d got=%b want=%b", cyc, cfg_ready, e_cfg_ready); end
            if (pipe_qh !== m_qh) begin n_fail++; $display("FAIL rand pipe_qh cyc=%0d got=%h want=%h", cyc, pipe_qh, m_qh); end
            if (e_out_valid) begin
                n_chk += 2;
                if (out_id !== 2'(e_out_id)) begin n_fail++; $display("FAIL rand out_id cyc=%0d got=%0d want=%0d", cyc, out_id, e_out_id); end
                if (out_t !== e_out_t) begin n_fail++; $display("FAIL rand out_t cyc=%0d got=%h want=%h", cyc, out_t, e_out_t); end
            end
            if (e_cfg_ready) ld = 1'b1;
            advance();
            if (ld) begin cfg_valid = 1'b0; ld = 1'b0; end
        end
    endtask

    initial begin
        @(negedge clk);
        test_reset();
        test_config(15'h1A2B);
        test_single();
        test_round_robin();
        test_wrap_skip();
        test_reconfig();
        test_reset_midflight();
        test_config(15'h2222);
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog got=timeout want=finish");
        $fatal(1, "watchdog expired");
    end
endmodule
